microc_param: RTL and testbench

- Parametrised successor of the single-cycle, data-memory-less microcontroller datapath.
- Generalises data width, IO port count and PC width.
- Adds a hardware return-address stack for subroutine call/return, a gated zero flag, and sticky stack-fault flags.
- Instruction memory is external: the block drives `pc` and receives `instr` combinationally in the same cycle. The control unit stays external and decodes `opcode`.

---
 rtl/microc_param_pkg.sv | 28 ++
 rtl/microc_param_if.sv | 35 +++
 rtl/microc_param_ret_stack.sv | 50 +++++
 rtl/microc_param.sv | 94 +++++++++
 tb/tb_microc_param.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/microc_param_pkg.sv
// Shared definitions for the parametrised microcontroller datapath:
// instruction field positions, ALU op encodings and a clog2 helper.
package microc_param_pkg;
  localparam int RD  = 12;  // write / rd3 address
  localparam int RS1 = 4;   // ALU operand a
  localparam int RS2 = 8;   // ALU operand b
  localparam int IMM = 4;   // 8-bit immediate
  localparam int JMP = 6;   // 10-bit jump target / relative offset
  localparam int OPC = 0;   // 6-bit opcode

  typedef enum logic [2:0] {
    ALU_A    = 3'b000,
    ALU_NOTA = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_NEGA = 3'b110,
    ALU_NEGB = 3'b111
  } alu_op_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/microc_param_if.sv
// Program-memory, control and IO bundle between the external control unit
// and the datapath core.
interface microc_param_if
  import microc_param_pkg::*;
#(
  parameter int DW    = 8,
  parameter int PCW   = 10,
  parameter int NPORT = 4
);
  localparam int SW = clog2(NPORT);

  logic [15:0]          instr;
  logic [PCW-1:0]       pc;
  logic                 s_inc, s_inc2, s_inm, s_inm2;
  logic                 we3, we_z, s_call, s_ret, enable;
  logic [SW-1:0]        s_IO;
  logic [2:0]           op;
  logic [NPORT*DW-1:0]  in;
  logic [5:0]           opcode;
  logic                 z;
  logic [NPORT*DW-1:0]  out;
  logic                 s_ovf, s_unf;

  modport master (
    output instr, s_inc, s_inc2, s_inm, s_inm2, we3, we_z, s_call, s_ret,
           enable, s_IO, op, in,
    input  pc, opcode, z, out, s_ovf, s_unf
  );

  modport slave (
    input  instr, s_inc, s_inc2, s_inm, s_inm2, we3, we_z, s_call, s_ret,
           enable, s_IO, op, in,
    output pc, opcode, z, out, s_ovf, s_unf
  );
endinterface

// File: rtl/microc_param_ret_stack.sv
// Return-address LIFO with sticky overflow/underflow flags; a push when full
// and a pop when empty are dropped and only raise the flag.
module ret_stack
  import microc_param_pkg::*;
#(
  parameter int PCW    = 10,
  parameter int SDEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] din,
  output logic [PCW-1:0] dout,
  output logic           full,
  output logic           empty,
  output logic           ovf,
  output logic           unf
);
  localparam int PW = clog2(SDEPTH) + 1;

  logic [PCW-1:0] mem [SDEPTH];
  logic [PW-1:0]  ptr;
  logic [PW-2:0]  top;

  assign full  = (ptr == PW'(SDEPTH));
  assign empty = (ptr == '0);
  // when full the low bits wrap to 0, so minus one still lands on the last slot
  assign top   = ptr[PW-2:0] - 1'b1;
  assign dout  = mem[top];

  always_ff @(posedge clk)
    if (push && !full) mem[ptr[PW-2:0]] <= din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (pop) begin
        if (empty) unf <= 1'b1;
        else       ptr <= ptr - 1'b1;
      end else if (push) begin
        if (full) ovf <= 1'b1;
        else      ptr <= ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/microc_param.sv
// Single-cycle microcontroller datapath: 16xDW register file, ALU, registered
// IO ports, PC sequencer with return-address stack.
module microc_param
  import microc_param_pkg::*;
#(
  parameter int DW     = 8,
  parameter int PCW    = 10,
  parameter int NPORT  = 4,
  parameter int SDEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  microc_param_if.slave bus
);
  logic [DW-1:0]              rf [16];
  logic [DW-1:0]              rd1, rd2, rd3, alu_y, wd;
  logic [NPORT-1:0][DW-1:0]   in_q, out_q;
  logic [PCW-1:0]             pc_q, pc_inc, pc_nx, jmp_abs, jmp_rel, stk_top;
  logic                       z_q, stk_empty, stk_full;

  assign rd1 = (bus.instr[RS1+:4] == 4'd0) ? '0 : rf[bus.instr[RS1+:4]];
  assign rd2 = (bus.instr[RS2+:4] == 4'd0) ? '0 : rf[bus.instr[RS2+:4]];
  assign rd3 = (bus.instr[RD+:4]  == 4'd0) ? '0 : rf[bus.instr[RD+:4]];

  always_comb begin
    alu_y = '0;
    case (alu_op_e'(bus.op))
      ALU_A:    alu_y = rd1;
      ALU_NOTA: alu_y = ~rd1;
      ALU_ADD:  alu_y = rd1 + rd2;
      ALU_SUB:  alu_y = rd1 - rd2;
      ALU_AND:  alu_y = rd1 & rd2;
      ALU_OR:   alu_y = rd1 | rd2;
      ALU_NEGA: alu_y = -rd1;
      ALU_NEGB: alu_y = -rd2;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    wd = alu_y;
    if (bus.s_inm) wd = bus.s_inm2 ? in_q[bus.s_IO] : DW'(bus.instr[IMM+:8]);
  end

  always_ff @(posedge clk)
    if (bus.we3) rf[bus.instr[RD+:4]] <= wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q  <= '0;
      out_q <= '0;
      z_q   <= 1'b0;
    end else begin
      in_q <= bus.in;
      if (bus.enable) out_q[bus.s_IO] <= rd3;
      if (bus.we_z)   z_q <= (alu_y == '0);
    end
  end

  ret_stack #(.PCW(PCW), .SDEPTH(SDEPTH)) u_stk (
    .clk   (clk),
    .reset (reset),
    .push  (bus.s_call && !bus.s_ret),
    .pop   (bus.s_ret),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .ovf   (bus.s_ovf),
    .unf   (bus.s_unf)
  );

  assign pc_inc  = pc_q + PCW'(1);
  assign jmp_abs = PCW'(bus.instr[JMP+:10]);
  assign jmp_rel = pc_q + PCW'(signed'(bus.instr[JMP+:10]));

  // a call that finds the stack full still jumps; only the push is lost
  always_comb begin
    pc_nx = pc_inc;
    if (bus.s_ret)       pc_nx = stk_empty ? pc_inc : stk_top;
    else if (bus.s_call) pc_nx = jmp_abs;
    else if (!bus.s_inc) pc_nx = jmp_abs;
    else if (bus.s_inc2) pc_nx = jmp_rel;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= '0;
    else       pc_q <= pc_nx;

  assign bus.pc     = pc_q;
  assign bus.z      = z_q;
  assign bus.out    = out_q;
  assign bus.opcode = bus.instr[OPC+:6];
endmodule

// File: tb/tb_microc_param.sv
// Directed bench for microc_param: IO, register file, zero flag, PC sequencing,
// return stack and asynchronous reset, with hand-computed expectations.
module tb_microc_param;
  localparam int DW = 8, PCW = 10, NPORT = 4, SDEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  microc_param_if #(.DW(DW), .PCW(PCW), .NPORT(NPORT)) bus ();

  microc_param #(.DW(DW), .PCW(PCW), .NPORT(NPORT), .SDEPTH(SDEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.instr  = 16'h0000;
    bus.s_inc  = 1'b1;
    bus.s_inc2 = 1'b0;
    bus.s_inm  = 1'b0;
    bus.s_inm2 = 1'b0;
    bus.we3    = 1'b0;
    bus.we_z   = 1'b0;
    bus.s_call = 1'b0;
    bus.s_ret  = 1'b0;
    bus.enable = 1'b0;
    bus.s_IO   = '0;
    bus.op     = 3'b000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic ldi(input logic [3:0] rd, input logic [7:0] imm);
    bus.instr = {rd, imm, 4'h0};
    bus.s_inm = 1'b1;
    bus.we3   = 1'b1;
    step();
  endtask

  task automatic outp(input logic [3:0] rs, input logic [1:0] port);
    bus.instr  = {rs, 12'h000};
    bus.enable = 1'b1;
    bus.s_IO   = port;
    step();
  endtask

  task automatic jmp(input logic [9:0] tgt);
    bus.instr = {tgt, 6'h00};
    bus.s_inc = 1'b0;
    step();
  endtask

  task automatic call(input logic [9:0] tgt);
    bus.instr  = {tgt, 6'h00};
    bus.s_call = 1'b1;
    step();
  endtask

  task automatic ret();
    bus.s_ret = 1'b1;
    step();
  endtask

  initial begin
    reset   = 1'b1;
    bus.in  = '0;
    idle();
    @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 0);
    chk("rst_z", bus.z, 0);
    chk("rst_out", bus.out, 0);
    chk("rst_flags", {bus.s_ovf, bus.s_unf}, 0);
    reset = 1'b0;

    // immediate load, output port select
    bus.instr = 16'h3A55;
    #1 chk("opcode", bus.opcode, 6'h15);
    ldi(4'd3, 8'hA5);
    chk("pc_seq", bus.pc, 1);
    outp(4'd3, 2'd2);
    chk("out_p2", bus.out, 32'h00A5_0000);

    // input ports are registered: same-cycle read sees the old value
    bus.in = 32'h0000_3C00;
    bus.instr = 16'h5000; bus.s_inm = 1'b1; bus.s_inm2 = 1'b1; bus.s_IO = 2'd1; bus.we3 = 1'b1;
    step();
    bus.instr = 16'h4000; bus.s_inm = 1'b1; bus.s_inm2 = 1'b1; bus.s_IO = 2'd1; bus.we3 = 1'b1;
    step();
    outp(4'd4, 2'd0);
    chk("in_p1", bus.out, 32'h00A5_003C);
    outp(4'd5, 2'd1);
    chk("in_lat", bus.out, 32'h00A5_003C);

    // zero flag gating and ALU
    ldi(4'd1, 8'h07);
    bus.instr = 16'h0110; bus.op = 3'b011;
    step();
    chk("z_gated", bus.z, 0);
    bus.instr = 16'h0110; bus.op = 3'b011; bus.we_z = 1'b1;
    step();
    chk("z_set", bus.z, 1);
    bus.instr = 16'h6110; bus.op = 3'b010; bus.we_z = 1'b1; bus.we3 = 1'b1;
    step();
    chk("z_clr", bus.z, 0);
    outp(4'd6, 2'd3);
    chk("alu_add", bus.out, 32'h0EA5_003C);
    ldi(4'd0, 8'hFF);
    outp(4'd0, 2'd1);
    chk("r0_zero", bus.out, 32'h0EA5_003C);

    // call / return
    jmp(10'd5);
    chk("jmp_abs", bus.pc, 5);
    call(10'd40);
    chk("call_pc", bus.pc, 40);
    step();
    ret();
    chk("ret_pc", bus.pc, 6);
    chk("ret_unf", bus.s_unf, 0);

    // nest SDEPTH+1 calls; the last overflows but still jumps
    for (int i = 0; i < SDEPTH + 1; i++) begin
      call(10'(100 + i));
      if (i == SDEPTH - 1) chk("ovf_pre", bus.s_ovf, 0);
    end
    chk("ovf_pc", bus.pc, 108);
    chk("ovf_set", bus.s_ovf, 1);
    for (int i = SDEPTH - 1; i >= 1; i--) begin
      ret();
      chk("unwind", bus.pc, 10'(100 + i));
    end
    ret();
    chk("unwind_last", bus.pc, 7);
    chk("unf_pre", bus.s_unf, 0);
    ret();
    chk("unf_pc", bus.pc, 8);
    chk("flags", {bus.s_ovf, bus.s_unf}, 2'b11);

    // relative branch and PC wrap
    jmp(10'd3);
    bus.instr = {10'h3FE, 6'h00}; bus.s_inc2 = 1'b1;
    step();
    chk("rel_neg", bus.pc, 1);
    jmp(10'h3FF);
    step();
    chk("pc_wrap", bus.pc, 0);

    // call+ret together: return wins and nothing is pushed
    call(10'd200);
    bus.instr = {10'd300, 6'h00}; bus.s_call = 1'b1; bus.s_ret = 1'b1;
    step();
    chk("callret_pc", bus.pc, 1);
    ret();
    chk("callret_nopush", bus.pc, 2);

    // asynchronous reset between edges
    bus.instr = 16'h0110; bus.op = 3'b011; bus.we_z = 1'b1;
    step();
    chk("z_pre_rst", bus.z, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_pc", bus.pc, 0);
    chk("arst_z", bus.z, 0);
    chk("arst_out", bus.out, 0);
    chk("arst_flags", {bus.s_ovf, bus.s_unf}, 0);
    #1 reset = 1'b0;
    step();
    chk("post_rst_pc", bus.pc, 1);
    outp(4'd4, 2'd0);
    chk("rf_kept", bus.out, 32'h0000_003C);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
